writeback_unit: RTL and testbench

// - Producer side of the register-file write port: merges execute results and load responses into
//   the single write port (write_valid/write_adr/write_data), one write per cycle.
// - Load results get byte/half/word extraction and sign/zero extension. Execute results are

---
 rtl/writeback_unit_pkg.sv | 20 ++
 rtl/writeback_unit_fifo.sv | 86 ++++++++
 rtl/writeback_unit.sv | 138 +++++++++++++
 tb/tb_writeback_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared core definitions used by the write-back stage: datapath widths,
// load size encoding and the entry type buffered between execute and write-back.
package writeback_unit_pkg;

    localparam int XLEN    = 32;
    localparam int NB_REGS = 5;

    // Encoding 2'b11 is not named; consumers treat it as a full word.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic [NB_REGS-1:0] rd;
        logic [XLEN-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Small synchronous FIFO of write-back entries. Besides the head it exposes the
// destination register of every occupied slot so the owner can flag read hazards.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            push_i,
    input  wb_entry_t                       push_entry_i,
    input  logic                            pop_i,
    output wb_entry_t                       head_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic [DEPTH-1:0]                valid_o,
    output logic [DEPTH-1:0][NB_REGS-1:0]   rd_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rel;

    // Next-state for pointers, occupancy and storage; DEPTH is a power of two so
    // pointer increments wrap on their own.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state: cleared asynchronously so a reset discards every queued entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; occupancy decides which slots are meaningful.
        mem_q <= mem_d;
    end

    // Slot i is occupied when its distance from the read pointer is below the count.
    always_comb begin
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel        = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = {1'b0, rel} < count_q;
            rd_o[i]    = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port producer: loads take priority, execute results are
// buffered when they lose the port, and decode sees hazards for in-flight writes.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int EXE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               exe_valid_i,
    output logic               exe_ready_o,
    input  logic [NB_REGS-1:0] exe_rd_i,
    input  logic [XLEN-1:0]    exe_data_i,
    input  logic               mem_valid_i,
    input  logic [NB_REGS-1:0] mem_rd_i,
    input  logic [XLEN-1:0]    mem_data_i,
    input  logic [1:0]         mem_size_i,
    input  logic               mem_unsigned_i,
    input  logic [1:0]         mem_offset_i,
    input  logic [NB_REGS-1:0] rs1_adr_i,
    input  logic [NB_REGS-1:0] rs2_adr_i,
    output logic               rs1_hazard_o,
    output logic               rs2_hazard_o,
    output logic               write_valid_o,
    output logic [NB_REGS-1:0] write_adr_o,
    output logic [XLEN-1:0]    write_data_o
);

    logic                                 exe_fire;
    logic                                 fifo_push, fifo_pop;
    logic                                 fifo_empty, fifo_full;
    wb_entry_t                            fifo_head;
    logic [EXE_DEPTH-1:0]                 fifo_valid;
    logic [EXE_DEPTH-1:0][NB_REGS-1:0]    fifo_rd;
    logic [7:0]                           ld_byte;
    logic [15:0]                          ld_half;
    logic [XLEN-1:0]                      load_data;
    logic                                 sel_valid;
    wb_entry_t                            sel_entry;
    logic                                 write_valid_q, write_valid_d;
    logic [NB_REGS-1:0]                   write_adr_q, write_adr_d;
    logic [XLEN-1:0]                      write_data_q, write_data_d;

    assign exe_ready_o = !fifo_full;
    assign exe_fire    = exe_valid_i && exe_ready_o;

    wb_fifo #(
        .DEPTH        (EXE_DEPTH)
    ) u_exe_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (fifo_push),
        .push_entry_i ('{rd: exe_rd_i, data: exe_data_i}),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .valid_o      (fifo_valid),
        .rd_o         (fifo_rd)
    );

    // Load formatting: pick the addressed byte/half and extend it to XLEN.
    always_comb begin
        ld_byte   = mem_data_i[{mem_offset_i, 3'b000} +: 8];
        ld_half   = mem_data_i[{mem_offset_i[1], 4'b0000} +: 16];
        load_data = mem_data_i;
        case (mem_size_i)
            SZ_B:    load_data = mem_unsigned_i ? {{(XLEN-8){1'b0}}, ld_byte}
                                                : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            SZ_H:    load_data = mem_unsigned_i ? {{(XLEN-16){1'b0}}, ld_half}
                                                : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: load_data = mem_data_i;
        endcase
    end

    // Port arbitration: load, then buffered result, then a bypassing execute result.
    // An execute transfer that does not win the port goes into the FIFO.
    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        sel_valid = 1'b0;
        sel_entry = '0;
        if (mem_valid_i) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: mem_rd_i, data: load_data};
            fifo_push = exe_fire;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_entry = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = exe_fire;
        end else if (exe_fire) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: exe_rd_i, data: exe_data_i};
        end
    end

    // Next write: an x0 destination is consumed but never enables the write.
    always_comb begin
        write_valid_d = sel_valid && (sel_entry.rd != '0);
        write_adr_d   = sel_valid ? sel_entry.rd   : write_adr_q;
        write_data_d  = sel_valid ? sel_entry.data : write_data_q;
    end

    // Registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_valid_q <= 1'b0;
            write_adr_q   <= '0;
            write_data_q  <= '0;
        end else begin
            write_valid_q <= write_valid_d;
            write_adr_q   <= write_adr_d;
            write_data_q  <= write_data_d;
        end
    end

    assign write_valid_o = write_valid_q;
    assign write_adr_o   = write_adr_q;
    assign write_data_o  = write_data_q;

    // Read hazards: a source matches any queued, registered or arriving write.
    always_comb begin
        rs1_hazard_o = (write_valid_q && write_adr_q == rs1_adr_i)
                    || (exe_fire && exe_rd_i == rs1_adr_i)
                    || (mem_valid_i && mem_rd_i == rs1_adr_i);
        rs2_hazard_o = (write_valid_q && write_adr_q == rs2_adr_i)
                    || (exe_fire && exe_rd_i == rs2_adr_i)
                    || (mem_valid_i && mem_rd_i == rs2_adr_i);
        for (int i = 0; i < EXE_DEPTH; i++) begin
            if (fifo_valid[i] && fifo_rd[i] == rs1_adr_i) rs1_hazard_o = 1'b1;
            if (fifo_valid[i] && fifo_rd[i] == rs2_adr_i) rs2_hazard_o = 1'b1;
        end
        rs1_hazard_o = rs1_hazard_o && (rs1_adr_i != '0);
        rs2_hazard_o = rs2_hazard_o && (rs2_adr_i != '0);
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: a queue-based reference model of the write port plus
// directed vectors with literal expectations for loads, ordering, x0 and reset.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int EXE_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exe_valid_i = 1'b0;
    logic        exe_ready_o;
    logic [4:0]  exe_rd_i = '0;
    logic [31:0] exe_data_i = '0;
    logic        mem_valid_i = 1'b0;
    logic [4:0]  mem_rd_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [1:0]  mem_size_i = '0;
    logic        mem_unsigned_i = 1'b0;
    logic [1:0]  mem_offset_i = '0;
    logic [4:0]  rs1_adr_i = '0;
    logic [4:0]  rs2_adr_i = '0;
    logic        rs1_hazard_o, rs2_hazard_o;
    logic        write_valid_o;
    logic [4:0]  write_adr_o;
    logic [31:0] write_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_unit #(.EXE_DEPTH(EXE_DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .exe_valid_i    (exe_valid_i),
        .exe_ready_o    (exe_ready_o),
        .exe_rd_i       (exe_rd_i),
        .exe_data_i     (exe_data_i),
        .mem_valid_i    (mem_valid_i),
        .mem_rd_i       (mem_rd_i),
        .mem_data_i     (mem_data_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .mem_offset_i   (mem_offset_i),
        .rs1_adr_i      (rs1_adr_i),
        .rs2_adr_i      (rs2_adr_i),
        .rs1_hazard_o   (rs1_hazard_o),
        .rs2_hazard_o   (rs2_hazard_o),
        .write_valid_o  (write_valid_o),
        .write_adr_o    (write_adr_o),
        .write_data_o   (write_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    wb_entry_t   q_m[$];
    logic        m_valid;
    logic [4:0]  m_adr;
    logic [31:0] m_data;
    int          load_run;

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [1:0] off);
        int unsigned v;
        int unsigned bits;
        if (size == 2'd0) begin
            v = (word >> (off * 8)) & 32'hFF;
            bits = 8;
        end else if (size == 2'd1) begin
            v = (word >> (off[1] * 16)) & 32'hFFFF;
            bits = 16;
        end else begin
            return word;
        end
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic model_clear();
        q_m.delete();
        m_valid  = 1'b0;
        m_adr    = '0;
        m_data   = '0;
        load_run = 0;
    endtask

    task automatic model_step();
        bit        ready;
        bit        fire;
        bit        have;
        wb_entry_t sel;
        wb_entry_t exe_e;
        ready      = q_m.size() < EXE_DEPTH;
        fire       = exe_valid_i && ready;
        have       = 1'b0;
        sel        = '0;
        exe_e.rd   = exe_rd_i;
        exe_e.data = exe_data_i;
        if (mem_valid_i) begin
            sel.rd   = mem_rd_i;
            sel.data = ref_load(mem_data_i, mem_size_i, mem_unsigned_i, mem_offset_i);
            have     = 1'b1;
            if (fire) q_m.push_back(exe_e);
        end else if (q_m.size() > 0) begin
            sel  = q_m.pop_front();
            have = 1'b1;
            if (fire) q_m.push_back(exe_e);
        end else if (fire) begin
            sel  = exe_e;
            have = 1'b1;
        end
        if (have) begin
            m_valid = (sel.rd != 0);
            m_adr   = sel.rd;
            m_data  = sel.data;
        end else begin
            m_valid = 1'b0;
        end
        load_run = mem_valid_i ? load_run + 1 : 0;
        assert (load_run <= EXE_DEPTH + 1) else $error("load stream without a gap");
    endtask

    function automatic logic exp_hazard(input logic [4:0] adr);
        if (adr == 0) return 1'b0;
        foreach (q_m[i]) if (q_m[i].rd == adr) return 1'b1;
        if (m_valid && m_adr == adr) return 1'b1;
        if (exe_valid_i && q_m.size() < EXE_DEPTH && exe_rd_i == adr) return 1'b1;
        if (mem_valid_i && mem_rd_i == adr) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    // Compare process: registered and combinational outputs every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            check("cmp_write_valid", write_valid_o, m_valid);
            if (m_valid) begin
                check("cmp_write_adr", write_adr_o, m_adr);
                check("cmp_write_data", write_data_o, m_data);
            end
            check("cmp_exe_ready", exe_ready_o, q_m.size() < EXE_DEPTH);
            check("cmp_rs1_hazard", rs1_hazard_o, exp_hazard(rs1_adr_i));
            check("cmp_rs2_hazard", rs2_hazard_o, exp_hazard(rs2_adr_i));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [1:0] sz, input logic uns, input logic [1:0] off);
        @(negedge clk);
        exe_valid_i    = ev;
        exe_rd_i       = erd;
        exe_data_i     = ed;
        mem_valid_i    = mv;
        mem_rd_i       = mrd;
        mem_data_i     = md;
        mem_size_i     = sz;
        mem_unsigned_i = uns;
        mem_offset_i   = off;
    endtask

    task automatic do_idle();
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic do_exe(input logic [4:0] rd, input logic [31:0] d);
        cyc(1'b1, rd, d, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] sz,
                           input logic uns, input logic [1:0] off);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, rd, d, sz, uns, off);
    endtask

    task automatic do_both(input logic [4:0] erd, input logic [31:0] ed,
                           input logic [4:0] mrd, input logic [31:0] md);
        cyc(1'b1, erd, ed, 1'b1, mrd, md, 2'd2, 1'b0, 2'd0);
    endtask

    task automatic settle();
        #4;
    endtask

    logic [1:0]  ld_size [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        ld_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  ld_off  [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] ld_exp  [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0,
                                 32'h0000_7F81, 32'h80F0_7F81};

    initial begin
        rs1_adr_i = 5'd5;
        rs2_adr_i = 5'd3;
        repeat (2) @(negedge clk);
        settle();
        check("rst_write_valid", write_valid_o, 1'b0);
        check("rst_write_adr", write_adr_o, 5'd0);
        check("rst_write_data", write_data_o, 32'h0);
        check("rst_exe_ready", exe_ready_o, 1'b1);
        check("rst_rs1_hazard", rs1_hazard_o, 1'b0);
        check("rst_rs2_hazard", rs2_hazard_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        check("post_rst_write_valid", write_valid_o, 1'b0);

        // Single execute result with a matching reader.
        do_exe(5'd5, 32'h1234);
        rs2_adr_i = 5'd0;
        settle();
        check("exe_hazard_transfer", rs1_hazard_o, 1'b1);
        do_idle();
        settle();
        check("exe_write_valid", write_valid_o, 1'b1);
        check("exe_write_adr", write_adr_o, 5'd5);
        check("exe_write_data", write_data_o, 32'h1234);
        check("exe_hazard_write", rs1_hazard_o, 1'b1);
        do_idle();
        settle();
        check("exe_hazard_clear", rs1_hazard_o, 1'b0);
        check("exe_write_done", write_valid_o, 1'b0);

        // Load extraction and extension.
        for (int i = 0; i < 5; i++) begin
            do_load(5'(10 + i), 32'h80F0_7F81, ld_size[i], ld_uns[i], ld_off[i]);
            do_idle();
            settle();
            check($sformatf("load%0d_adr", i), write_adr_o, 5'(10 + i));
            check($sformatf("load%0d_data", i), write_data_o, ld_exp[i]);
        end

        // Same-cycle execute and load: load first, execute next.
        rs2_adr_i = 5'd4;
        do_both(5'd3, 32'h1, 5'd4, 32'h44);
        settle();
        check("conflict_rs2_hazard", rs2_hazard_o, 1'b1);
        do_idle();
        settle();
        check("conflict_first_adr", write_adr_o, 5'd4);
        check("conflict_first_data", write_data_o, 32'h44);
        do_idle();
        settle();
        check("conflict_second_adr", write_adr_o, 5'd3);
        check("conflict_second_data", write_data_o, 32'h1);
        rs2_adr_i = 5'd0;

        // Three loads in a row while execute keeps pushing: FIFO fills.
        do_both(5'd20, 32'h20, 5'd8, 32'h8);
        do_both(5'd21, 32'h21, 5'd9, 32'h9);
        settle();
        check("fill_w0_adr", write_adr_o, 5'd8);
        do_both(5'd22, 32'h22, 5'd10, 32'h10);
        settle();
        check("fill_full_ready", exe_ready_o, 1'b0);
        check("fill_w1_adr", write_adr_o, 5'd9);
        do_exe(5'd22, 32'h22);
        settle();
        check("fill_still_full", exe_ready_o, 1'b0);
        check("fill_w2_adr", write_adr_o, 5'd10);
        do_exe(5'd22, 32'h22);
        settle();
        check("fill_ready_again", exe_ready_o, 1'b1);
        check("fill_w3_adr", write_adr_o, 5'd20);
        do_idle();
        settle();
        check("fill_w4_adr", write_adr_o, 5'd21);
        do_idle();
        settle();
        check("fill_w5_adr", write_adr_o, 5'd22);
        check("fill_w5_data", write_data_o, 32'h22);
        do_idle();
        settle();
        check("fill_drained", write_valid_o, 1'b0);

        // x0 destination: consumed, never written, never a hazard.
        rs1_adr_i = 5'd0;
        do_exe(5'd0, 32'hDEAD);
        settle();
        check("x0_rs1_hazard", rs1_hazard_o, 1'b0);
        do_idle();
        settle();
        check("x0_no_write", write_valid_o, 1'b0);

        // Asynchronous reset with two buffered results.
        do_both(5'd6, 32'h66, 5'd11, 32'h11);
        do_both(5'd7, 32'h77, 5'd12, 32'h12);
        rs1_adr_i = 5'd6;
        do_idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_write_valid", write_valid_o, 1'b0);
        check("arst_write_adr", write_adr_o, 5'd0);
        check("arst_write_data", write_data_o, 32'h0);
        check("arst_exe_ready", exe_ready_o, 1'b1);
        check("arst_rs1_hazard", rs1_hazard_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            do_idle();
            settle();
            check("arst_no_write_after", write_valid_o, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
